// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron array.
// Holds the sweep FSM states, the default parameter set and the width
// helpers used by lif_core and lif_array.
package lif_pkg;

  localparam int unsigned LIF_N_DEF          = 4;
  localparam int unsigned LIF_W_DEF          = 8;
  localparam int unsigned LIF_LEAK_SHIFT_DEF = 2;
  localparam int unsigned LIF_REFRAC_DEF     = 2;

  typedef enum logic {
    LIF_IDLE  = 1'b0,
    LIF_SWEEP = 1'b1
  } lif_state_t;

  // One extra bit catches the carry of the leak-then-add sum before saturation.
  function automatic int unsigned sum_width(input int unsigned w);
    return w + 1;
  endfunction

  // Refractory counter width; at least one bit so a zero period still has a flop.
  function automatic int unsigned rc_width(input int unsigned refrac);
    return (refrac == 0) ? 32'd1 : 32'($clog2(refrac + 1));
  endfunction

endpackage

// File: rtl/lif_core.sv
// Combinational single-neuron leaky integrate-and-fire update.
// Ports: v/rc    - current membrane value and refractory count
//        cur     - input current for this neuron
//        thresh  - firing threshold (0 disables firing)
//        v_next_c/rc_next_c/fire_c - updated state and spike bit
module lif_core
  import lif_pkg::*;
#(
  parameter int unsigned W          = LIF_W_DEF,
  parameter int unsigned LEAK_SHIFT = LIF_LEAK_SHIFT_DEF,
  parameter int unsigned REFRAC     = LIF_REFRAC_DEF,
  parameter int unsigned RW         = rc_width(REFRAC)
) (
  input  logic [W-1:0]  v,
  input  logic [RW-1:0] rc,
  input  logic [W-1:0]  cur,
  input  logic [W-1:0]  thresh,
  output logic [W-1:0]  v_next_c,
  output logic [RW-1:0] rc_next_c,
  output logic          fire_c
);

  localparam int unsigned SW = sum_width(W);

  logic [SW-1:0] sum;
  logic [W-1:0]  vn;

  // Leak never underflows (v >> k <= v), so only the add can carry out.
  always_comb begin
    sum       = SW'(v) - SW'(v >> LEAK_SHIFT) + SW'(cur);
    vn        = sum[W] ? {W{1'b1}} : sum[W-1:0];
    v_next_c  = vn;
    rc_next_c = rc;
    fire_c    = 1'b0;
    if (rc != '0) begin
      v_next_c  = '0;
      rc_next_c = rc - RW'(1);
    end else if ((thresh != '0) && (vn >= thresh)) begin
      fire_c    = 1'b1;
      v_next_c  = '0;
      rc_next_c = RW'(REFRAC);
    end
  end

endmodule

// File: rtl/lif_array.sv
// Array of N LIF neurons sharing one update datapath, one neuron per clock.
// Ports: clk, rst_n (async active-low)
//        en          - tick strobe, starts a sweep when idle
//        cur_in      - N packed currents, channel k at [k*W +: W]
//        thresh      - shared firing threshold (0 disables firing)
//        spike       - spike vector of the last completed sweep
//        spike_valid - one-cycle pulse when spike updates
//        busy        - sweep in progress
//        overrun     - sticky, en seen while busy
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned N          = LIF_N_DEF,
  parameter int unsigned W          = LIF_W_DEF,
  parameter int unsigned LEAK_SHIFT = LIF_LEAK_SHIFT_DEF,
  parameter int unsigned REFRAC     = LIF_REFRAC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N*W-1:0] cur_in,
  input  logic [W-1:0]   thresh,
  output logic [N-1:0]   spike,
  output logic           spike_valid,
  output logic           busy,
  output logic           overrun
);

  localparam int unsigned RW = rc_width(REFRAC);
  localparam int unsigned IW = $clog2(N);

  lif_state_t    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  v_q  [N];
  logic [RW-1:0] rc_q [N];
  logic [N-1:0]  shadow;

  logic [W-1:0]  cur_sel;
  logic [W-1:0]  v_sel;
  logic [RW-1:0] rc_sel;
  logic [W-1:0]  v_nx;
  logic [RW-1:0] rc_nx;
  logic          fire;
  logic [N-1:0]  shadow_nx;
  logic          last;

  // Select the neuron under update and merge its spike into the shadow.
  always_comb begin
    cur_sel        = cur_in[int'(idx)*W +: W];
    v_sel          = v_q[idx];
    rc_sel         = rc_q[idx];
    shadow_nx      = shadow;
    shadow_nx[idx] = fire;
    last           = (idx == IW'(N - 1));
  end

  lif_core #(
    .W          (W),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRAC     (REFRAC),
    .RW         (RW)
  ) u_core (
    .v         (v_sel),
    .rc        (rc_sel),
    .cur       (cur_sel),
    .thresh    (thresh),
    .v_next_c  (v_nx),
    .rc_next_c (rc_nx),
    .fire_c    (fire)
  );

  // Sweep FSM, neuron state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LIF_IDLE;
      idx         <= '0;
      shadow      <= '0;
      spike       <= '0;
      spike_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      for (int k = 0; k < N; k++) begin
        v_q[k]  <= '0;
        rc_q[k] <= '0;
      end
    end else begin
      spike_valid <= 1'b0;
      // A strobe on the final sweep cycle is still rejected.
      if (en && (state == LIF_SWEEP)) overrun <= 1'b1;
      case (state)
        LIF_IDLE: begin
          if (en) begin
            state <= LIF_SWEEP;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        LIF_SWEEP: begin
          v_q[idx]  <= v_nx;
          rc_q[idx] <= rc_nx;
          shadow    <= shadow_nx;
          if (last) begin
            spike       <= shadow_nx;
            spike_valid <= 1'b1;
            busy        <= 1'b0;
            idx         <= '0;
            state       <= LIF_IDLE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= LIF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array: directed vector table, multi-cycle
// corner sequences and randomized ticks against a behavioural model.
module tb_lif_array;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int LS     = 2;
  localparam int REFRAC = 2;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic [N*W-1:0] cur_in;
  logic [W-1:0]   thresh;
  logic [N-1:0]   spike;
  logic           spike_valid;
  logic           busy;
  logic           overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int v_m  [N];
  int rc_m [N];

  typedef struct {
    bit          rst;
    logic [31:0] cur;
    logic [7:0]  th;
    logic [3:0]  exp;
  } vec_t;

  vec_t tbl[$];

  lif_array #(
    .N          (N),
    .W          (W),
    .LEAK_SHIFT (LS),
    .REFRAC     (REFRAC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cur_in      (cur_in),
    .thresh      (thresh),
    .spike       (spike),
    .spike_valid (spike_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < N; k++) begin
      v_m[k]  = 0;
      rc_m[k] = 0;
    end
  endfunction

  // Reference: one whole tick applied to every neuron with integer arithmetic.
  function automatic logic [3:0] model_tick(input logic [31:0] c, input logic [7:0] th);
    logic [3:0] s;
    int cur, nv;
    s = '0;
    for (int k = 0; k < N; k++) begin
      cur = int'(c[k*W +: W]);
      if (rc_m[k] > 0) begin
        v_m[k]  = 0;
        rc_m[k] = rc_m[k] - 1;
      end else begin
        nv = v_m[k] - v_m[k] / (1 << LS) + cur;
        if (nv > 255) nv = 255;
        if (th != 0 && nv >= int'(th)) begin
          s[k]    = 1'b1;
          v_m[k]  = 0;
          rc_m[k] = REFRAC;
        end else begin
          v_m[k] = nv;
        end
      end
    end
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    cur_in = $urandom;
    thresh = 8'($urandom);
    en     = 1'($urandom);
    @(negedge clk);
    check("rst_spike", 32'(spike), 0);
    check("rst_valid", 32'(spike_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One tick: strobe, check busy and pulse timing, return the spike vector.
  task automatic tick(input logic [31:0] c, input logic [7:0] th, output logic [3:0] spk);
    @(negedge clk);
    cur_in = c;
    thresh = th;
    en     = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("busy_rise", 32'(busy), 1);
    repeat (N - 1) @(negedge clk);
    check("valid_early", 32'(spike_valid), 0);
    @(negedge clk);
    check("valid_pulse", 32'(spike_valid), 1);
    check("busy_fall", 32'(busy), 0);
    spk = spike;
    @(negedge clk);
    check("valid_width", 32'(spike_valid), 0);
  endtask

  // Strobes at relative edges 0 and gap; count spike_valid pulses over 16 edges.
  task automatic sched(input int gap, input int exp_cnt, input int exp_first, input logic exp_ov);
    int cnt;
    int first;
    cnt    = 0;
    first  = -1;
    cur_in = '0;
    thresh = 8'd100;
    for (int c = 0; c < 16; c++) begin
      en = (c == 0) || (c == gap);
      @(negedge clk);
      if (spike_valid) begin
        if (first < 0) first = c;
        cnt++;
      end
    end
    en = 1'b0;
    check($sformatf("sched%0d_pulses", gap), 32'(cnt), 32'(exp_cnt));
    check($sformatf("sched%0d_first", gap), 32'(first), 32'(exp_first));
    check($sformatf("sched%0d_overrun", gap), 32'(overrun), 32'(exp_ov));
  endtask

  function automatic void add(input bit r, input logic [31:0] c, input logic [7:0] th, input logic [3:0] e);
    vec_t x;
    x.rst = r;
    x.cur = c;
    x.th  = th;
    x.exp = e;
    tbl.push_back(x);
  endfunction

  initial begin
    logic [3:0]  spk;
    logic [3:0]  exp_s;
    logic [31:0] c;
    logic [7:0]  th;
    int          cnt;

    rst_n  = 1'b0;
    en     = 1'b0;
    cur_in = '0;
    thresh = '0;

    // First tick after reset with zero currents.
    add(1, 32'h0, 8'd100, 4'b0000);
    // Integrate-and-fire on ch0: fire on tick 6, refractory 7-8, restart 9, fire 14.
    for (int t = 1; t <= 14; t++)
      add(0, 32'h0000_001E, 8'd100, (t == 6 || t == 14) ? 4'b0001 : 4'b0000);
    // Saturation on ch1 with threshold at full scale.
    add(1, 32'h0000_C800, 8'd255, 4'b0000);
    add(0, 32'h0000_C800, 8'd255, 4'b0010);
    // Threshold 0 disables firing; membranes pin at 255.
    for (int t = 0; t < 10; t++)
      add(t == 0, 32'hFFFF_FFFF, 8'd0, 4'b0000);
    // From 255 with no input the leak gives exactly 192.
    add(0, 32'h0, 8'd192, 4'b1111);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      tick(tbl[i].cur, tbl[i].th, spk);
      check($sformatf("vec%0d_spike", i), 32'(spk), 32'(tbl[i].exp));
    end

    // Strobe spacing: N-2 and N rejected, N+1 accepted.
    do_reset();
    sched(2, 1, 4, 1'b1);
    repeat (3) @(negedge clk);
    check("overrun_sticky", 32'(overrun), 1);
    do_reset();
    sched(4, 1, 4, 1'b1);
    do_reset();
    sched(5, 2, 4, 1'b0);

    // Reset in the middle of a sweep: no pulse, state cleared.
    do_reset();
    @(negedge clk);
    cur_in = 32'h0000_001E;
    thresh = 8'd31;
    en     = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    cnt   = 0;
    for (int c2 = 0; c2 < 6; c2++) begin
      @(negedge clk);
      if (spike_valid) cnt++;
    end
    check("abort_no_pulse", 32'(cnt), 0);
    check("abort_busy", 32'(busy), 0);
    rst_n = 1'b1;
    model_clear();
    tick(32'h0000_001E, 8'd31, spk);
    check("abort_v30", 32'(spk), 0);
    tick(32'h0000_001E, 8'd31, spk);
    check("abort_v53_fire", 32'(spk), 1);

    // Randomized ticks against the reference model.
    do_reset();
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < N; k++)
        c[k*W +: W] = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 90));
      th = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(40, 255));
      exp_s = model_tick(c, th);
      tick(c, th, spk);
      check($sformatf("rand%0d_spike", t), 32'(spk), 32'(exp_s));
    end
    check("final_overrun", 32'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_array.md
# lif_array

Time-multiplexed array of N leaky integrate-and-fire neurons. It generalises the single-neuron LIF block with parametrised membrane width, channel count, leak shift and a refractory period. Each enable tick, one shared update datapath sweeps all neurons, one neuron per clock. It sits behind the tick prescaler in the project top; spikes drive `uo_out`.

## Interface
Parameters:
- `N` = 4: neuron count (≥2)
- `W` = 8: membrane/current/threshold width
- `LEAK_SHIFT` = 2: leak is `v >> LEAK_SHIFT` per tick (1..W-1)
- `REFRAC` = 2: refractory length in ticks after a spike (0 = none)

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `en` in 1: tick strobe; one sweep is started per accepted strobe
- `cur_in` in N*W: input currents, channel k at `[k*W +: W]`, unsigned
- `thresh` in W: shared firing threshold, unsigned; 0 disables firing
- `spike` out N: spike vector of last completed sweep, registered
- `spike_valid` out 1: one-cycle pulse when `spike` updates
- `busy` out 1: sweep in progress
- `overrun` out 1: sticky; set when `en` arrives while busy; cleared only by reset

## Operation
- FSM states:
  - IDLE → SWEEP on `en`=1. Index clears to 0.
  - SWEEP processes neuron `idx` each cycle. At `idx`=N-1 it returns to IDLE.
- Per neuron, using `v` (W bits), `rc` (refractory counter, ceil(log2(REFRAC+1)) bits, min 1) and `I = cur_in[idx]` sampled that cycle:
  - Refractory (`rc`≠0):
    - `v` ← 0, `rc` ← `rc`-1, spike bit 0.
    - `I` is ignored.
  - Otherwise:
    - Compute `s = v - (v >> LEAK_SHIFT) + I` in W+1 bits.
    - `vn = s` saturated to 2^W-1.
    - If `thresh`≠0 and `vn` ≥ `thresh`: spike bit 1, `v` ← 0, `rc` ← REFRAC.
    - Else: spike bit 0, `v` ← `vn`.
- Spike bits accumulate in a shadow vector. The shadow is copied to `spike` on the final sweep cycle. `spike` holds until the next sweep completes.
- `en` while `busy`=1: ignored, `overrun` ← 1. The sweep is unaffected.
- `cur_in`/`thresh` changes mid-sweep take effect for neurons not yet processed.
- Reset values: every `v`=0, every `rc`=0, `spike`=0, `spike_valid`=0, `busy`=0, `overrun`=0, FSM IDLE, `idx`=0.
- Reset during SWEEP aborts it immediately. No `spike_valid` pulse is produced.

## Timing
- `en` sampled high at edge t (IDLE):
  - `busy`=1 for cycles t+1..t+N.
  - Neuron k is updated at edge t+1+k.
  - `spike`, and `spike_valid`=1, are visible after edge t+N for exactly one cycle.
- `busy` drops after edge t+N. `en` sampled at edge t+N is rejected (overrun). `en` sampled at edge t+N+1 is accepted. Minimum tick spacing is N+1 cycles.
- Latency from tick to spike visible: N cycles after the accepting edge.
- `spike` and `spike_valid` are driven from flops only. There are no combinational input→output paths.

## Structure
- Package `lif_pkg`:
  - FSM state enum (`LIF_IDLE`, `LIF_SWEEP`)
  - saturating-add width helper
  - default parameter constants
- Sub-module `lif_core`: combinational single-neuron update. It takes `v`, `rc`, `I`, `thresh` and produces next `v`, next `rc` and spike. It is parametrised by W, LEAK_SHIFT, REFRAC.
- `lif_array` holds the state arrays (flop arrays, N×(W + rc bits)), the FSM, the index counter, the shadow spike vector and the overrun flag.

## Test plan
Defaults apply: N=4, W=8, LEAK_SHIFT=2, REFRAC=2, `thresh`=100.
- Reset: drive `rst_n`=0 with random inputs → `spike`=0, `spike_valid`=0, `busy`=0, `overrun`=0. The first tick after release with all `cur_in`=0 yields `spike`=0.
- Integrate and fire: ch0 `I`=30, others 0, tick every 8 cycles.
  - ch0 `v` sequence: 30, 53, 70, 83, 93, then 100 → `spike`=4'b0001 on tick 6 only.
  - Ticks 7–8 are refractory (`spike`[0]=0).
  - Integration restarts from 0 on tick 9 (`v`=30).
- Saturation: ch1 `I`=200, `thresh`=255.
  - Tick 1: `v`=200, no spike.
  - Tick 2: 350 saturates to 255 → `spike`[1]=1.
- Disabled threshold: `thresh`=0, all `I`=255 for 10 ticks → `spike` stays 0; `v` stays saturated at 255.
- Overrun: `en` at t and t+2 → only one `spike_valid` pulse (after edge t+4); `overrun`=1 and sticky. `en` at t+5 is accepted without setting `overrun`.
- Reset mid-sweep: `en` at t, `rst_n`=0 at cycle t+2 → no `spike_valid` pulse; all `v` read 0 on the next accepted tick (ch0 `I`=30 gives `v`=30).
